display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller that shares one BCD-to-7-segment decoder (7448-style, with BCD input, lamp-test input and blanking) across `NUM_DIGITS` common-cathode digits. It double-buffers a packed BCD word and steps through the digits one at a time. For each digit it drives the decoder's BCD, lamp-test and blank inputs and a one-hot digit enable. A dead-time gap between digits prevents ghosting. It sits between the register/bus side of a display peripheral and the shared decoder instance.

## Interface
- `NUM_DIGITS`, 4: digits scanned; must be ≥ 2.
- `PRESCALE`, 1000: clock cycles per digit slot, including dead time.
- `DEAD_CYCLES`, 2: cycles per slot with all enables low; must be ≥ 1 and < `PRESCALE`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `bcd_in` in 4*NUM_DIGITS: packed digits; `[3:0]` is digit 0, the least significant digit.
- `load` in 1: capture `bcd_in` into the pending buffer.
- `lt` in 1: lamp-test request.
- `blank_lz` in 1: enable leading-zero blanking.
- `bcd` out 4: BCD value to the decoder.
- `lt_out` out 1: lamp-test to the decoder.
- `blank` out 1: blank request to the decoder/driver.
- `digit_en` out NUM_DIGITS: one-hot digit enable; all zero during dead time.
- `frame_done` out 1: one-cycle pulse at the end of each full scan.

## Operation
- Buffers: `pending` (4*NUM_DIGITS), `pending_valid`, and `active` (4*NUM_DIGITS).
  - `load` → `pending` <= `bcd_in` and `pending_valid` <= 1.
  - Frame-boundary edge with `pending_valid` → `active` <= pre-edge `pending` and `pending_valid` <= 0.
  - `load` on the boundary edge: `active` takes the old `pending`; the new value goes to `pending` and `pending_valid` stays 1.
- FSM has two states.
  - `S_DEAD`: `digit_en` = 0. When `cnt` == DEAD_CYCLES-1 → `S_ON`, `cnt` <= 0.
  - `S_ON`: `digit_en` = one-hot(`idx`). When `cnt` == PRESCALE-DEAD_CYCLES-1 → `S_DEAD`, `cnt` <= 0, `idx` <= (`idx`+1) mod NUM_DIGITS.
  - Wrap from `idx` NUM_DIGITS-1 to 0 is the frame boundary: `frame_done` = 1 for that cycle, and the buffer copy happens.
- Per-slot outputs are registered at the edge entering `S_DEAD` of `idx` and held through that slot's `S_ON`:
  - `bcd` = `active[4*idx +: 4]`. Values 10–15 pass through unchanged; the decoder blanks them.
  - `blank` = `blank_lz` AND `idx` ≠ 0 AND every digit from `idx` up to NUM_DIGITS-1 equals 0. Digit 0 is never blanked.
- Lamp test is re-registered every cycle and is not slot-aligned.
  - `lt_out` <= `lt`.
  - When `lt` = 1, `blank` is forced to 0 on the same edge.
  - Scanning continues during lamp test.

## Timing
- Reset values:
  - State `S_DEAD`, `idx` 0, `cnt` 0.
  - `digit_en` 0, `bcd` 0, `blank` 0, `lt_out` 0, `frame_done` 0.
  - `pending` 0, `active` 0, `pending_valid` 0.
- Reset asserted mid-`S_ON`: all enables go low immediately, with no wait for the clock.
- After reset release, digit 0 enable rises on the `DEAD_CYCLES`-th rising edge and stays high PRESCALE-DEAD_CYCLES cycles.
- Frame length is NUM_DIGITS*PRESCALE cycles; `frame_done` has that period.
- Reset does not perform a buffer copy. A `load` in the first frame is displayed from the second frame.
- `bcd` and `blank` are stable for at least DEAD_CYCLES cycles before `digit_en` rises.

## Structure
- Shared package `display_pkg`:
  - State encoding `S_DEAD` / `S_ON`.
  - `BCD_W` = 4.
  - `bcd_is_zero` helper.
- Sub-module `scan_timer`:
  - Contains `cnt`, the FSM and `idx`.
  - Outputs `slot_start` (entering `S_DEAD`), `on`, `idx` and `frame_wrap`.
- The top level holds the buffers, the blanking logic and the output registers.

## Test plan
All scenarios use NUM_DIGITS=4, PRESCALE=8, DEAD_CYCLES=2.
- Reset, then `load` `bcd_in`=16'h1234 at cycle 1 → frame 1 shows `bcd` 0,0,0,0; from cycle 32, frame 2 shows `bcd` 4,3,2,1 with `digit_en` 0001,0010,0100,1000.
- Steady scan → each enable high 6 cycles, separated by 2 all-zero cycles; `frame_done` pulses at cycles 31, 63, 95.
- `blank_lz`=1 with 16'h0040 → `blank` 0,0,1,1 for digits 0..3. With 16'h0000 → `blank` 0,1,1,1. With `blank_lz`=0 → all `blank` 0.
- `lt`=1 mid-slot with 16'h0000 and `blank_lz`=1 → next edge `lt_out`=1 and `blank`=0 on every digit; the `digit_en` sequence is unchanged.
- `load` 16'h9999 exactly on the frame-boundary edge, with pending 16'h5555 → next frame shows 5s, the following frame shows 9s.
- `reset` asserted 3 cycles into digit 2's `S_ON` → `digit_en` = 0 immediately. After release, the scan restarts at digit 0 and `active` = 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

    typedef enum logic {
        S_DEAD = 1'b0,
        S_ON   = 1'b1
    } scan_state_t;

    localparam int BCD_W = 4;

    function automatic logic bcd_is_zero(input logic [BCD_W-1:0] d);
        return (d == '0);
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot timer: dead-time / on-time FSM, per-slot counter and digit index.
module scan_timer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 1000,
    parameter int DEAD_CYCLES = 2,
    localparam int IDX_W      = $clog2(NUM_DIGITS),
    localparam int CNT_W      = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             slot_start,
    output logic             on,
    output logic [IDX_W-1:0] idx,
    output logic             frame_wrap
);

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(PRESCALE - DEAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_DEAD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        slot_start = 1'b0;
        frame_wrap = 1'b0;
        case (state_q)
            S_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d    = S_DEAD;
                    cnt_d      = '0;
                    slot_start = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d      = '0;
                        frame_wrap = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    assign on  = (state_q == S_ON);
    assign idx = idx_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Double-buffered BCD scan controller driving one shared 7448-style decoder
// across NUM_DIGITS common-cathode digits, with leading-zero blanking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 1000,
    parameter int DEAD_CYCLES = 2,
    localparam int IDX_W      = $clog2(NUM_DIGITS),
    localparam int WORD_W     = BCD_W * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_W-1:0]     bcd_in,
    input  logic                  load,
    input  logic                  lt,
    input  logic                  blank_lz,
    output logic [BCD_W-1:0]      bcd,
    output logic                  lt_out,
    output logic                  blank,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done
);

    logic             slot_start, on, frame_wrap;
    logic [IDX_W-1:0] idx, idx_next;

    logic [WORD_W-1:0] pending_q, active_q, active_d;
    logic              pending_valid_q;
    logic              blank_slot_q, blank_d, lead_zero;
    logic              lt_q;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .slot_start(slot_start),
        .on        (on),
        .idx       (idx),
        .frame_wrap(frame_wrap)
    );

    // Slot outputs are computed from the post-copy buffer and the next index,
    // so the first slot of a new frame already shows the freshly copied word.
    always_comb begin
        active_d = (frame_wrap && pending_valid_q) ? pending_q : active_q;
        idx_next = frame_wrap ? '0 : idx + IDX_W'(1);
    end

    always_comb begin
        lead_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_next) && !bcd_is_zero(active_d[BCD_W*i +: BCD_W]))
                lead_zero = 1'b0;
        end
        blank_d = blank_lz && (idx_next != '0) && lead_zero;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
        end else begin
            if (frame_wrap && pending_valid_q) begin
                active_q        <= pending_q;
                pending_valid_q <= 1'b0;
            end
            if (load) begin
                pending_q       <= bcd_in;
                pending_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd          <= '0;
            blank_slot_q <= 1'b0;
            lt_q         <= 1'b0;
        end else begin
            lt_q <= lt;
            if (slot_start) begin
                bcd          <= active_d[BCD_W*idx_next +: BCD_W];
                blank_slot_q <= blank_d;
            end
        end
    end

    always_comb begin
        digit_en = '0;
        if (on)
            digit_en[idx] = 1'b1;
    end

    // Lamp test overrides blanking as soon as it is registered, independent of slot timing.
    assign lt_out     = lt_q;
    assign blank      = blank_slot_q & ~lt_q;
    assign frame_done = frame_wrap;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 dead cycles).
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic        load, lt, blank_lz;
    logic [3:0]  bcd;
    logic        lt_out, blank, frame_done;
    logic [3:0]  digit_en;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic lt_prev     = 1'b0;

    display_scan_ctrl #(
        .NUM_DIGITS (4),
        .PRESCALE   (8),
        .DEAD_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bcd_in    (bcd_in),
        .load      (load),
        .lt        (lt),
        .blank_lz  (blank_lz),
        .bcd       (bcd),
        .lt_out    (lt_out),
        .blank     (blank),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        lt_prev = lt;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Checks one full 32-cycle frame starting at a frame boundary; optional loads and lamp-test onset.
    task automatic check_frame(input logic [15:0] exp_active, input logic [3:0] exp_blank,
                               input int la, input logic [15:0] lva,
                               input int lb, input logic [15:0] lvb, input int lt_at);
        for (int j = 0; j < 32; j++) begin
            int         s;
            logic [3:0] e_en;
            logic [3:0] e_bcd;
            logic       e_blank;
            logic       e_fd;
            s       = j / 8;
            e_en    = ((j % 8) >= 2) ? (4'b0001 << s) : 4'b0000;
            e_bcd   = exp_active[4*s +: 4];
            e_blank = exp_blank[s] & ~lt_prev;
            e_fd    = (j == 31);
            vectors++;
            if (digit_en !== e_en) begin
                miscompares++;
                $display("FAIL digit_en cyc %0d: got %b want %b", cyc, digit_en, e_en);
            end
            vectors++;
            if (bcd !== e_bcd) begin
                miscompares++;
                $display("FAIL bcd cyc %0d: got %h want %h", cyc, bcd, e_bcd);
            end
            vectors++;
            if (blank !== e_blank) begin
                miscompares++;
                $display("FAIL blank cyc %0d: got %b want %b", cyc, blank, e_blank);
            end
            vectors++;
            if (frame_done !== e_fd) begin
                miscompares++;
                $display("FAIL frame_done cyc %0d: got %b want %b", cyc, frame_done, e_fd);
            end
            vectors++;
            if (lt_out !== lt_prev) begin
                miscompares++;
                $display("FAIL lt_out cyc %0d: got %b want %b", cyc, lt_out, lt_prev);
            end
            if (j == la) begin bcd_in = lva; load = 1'b1; end
            if (j == lb) begin bcd_in = lvb; load = 1'b1; end
            if (j == lt_at) lt = 1'b1;
            tick();
            load = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; lt = 1'b0; blank_lz = 1'b0; bcd_in = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({digit_en, bcd, blank, lt_out, frame_done} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got en=%b bcd=%h blank=%b lt_out=%b fd=%b want all 0",
                     digit_en, bcd, blank, lt_out, frame_done);
        end
        reset   = 1'b0;
        cyc     = 0;
        lt_prev = 1'b0;
    endtask

    task automatic test_first_load();
        check_frame(16'h0000, 4'b0000, 1, 16'h1234, -1, 16'h0, -1);
    endtask

    task automatic test_steady_scan();
        check_frame(16'h1234, 4'b0000, -1, 16'h0, -1, 16'h0, -1);
        check_frame(16'h1234, 4'b0000, -1, 16'h0, -1, 16'h0, -1);
    endtask

    task automatic test_blank_lz();
        blank_lz = 1'b1;
        check_frame(16'h1234, 4'b0000, 5, 16'h0040, -1, 16'h0, -1);
        check_frame(16'h0040, 4'b1100, 5, 16'h0000, -1, 16'h0, -1);
        check_frame(16'h0000, 4'b1110, -1, 16'h0, -1, 16'h0, -1);
        blank_lz = 1'b0;
        check_frame(16'h0000, 4'b0000, -1, 16'h0, -1, 16'h0, -1);
    endtask

    task automatic test_lamp_test();
        blank_lz = 1'b1;
        check_frame(16'h0000, 4'b1110, -1, 16'h0, -1, 16'h0, 12);
        check_frame(16'h0000, 4'b1110, -1, 16'h0, -1, 16'h0, -1);
        lt       = 1'b0;
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        check_frame(16'h0000, 4'b0000, 3, 16'h5555, 31, 16'h9999, -1);
        check_frame(16'h5555, 4'b0000, -1, 16'h0, -1, 16'h0, -1);
        check_frame(16'h9999, 4'b0000, -1, 16'h0, -1, 16'h0, -1);
    endtask

    task automatic test_reset_mid_scan();
        repeat (21) tick();
        vectors++;
        if (digit_en !== 4'b0100) begin
            miscompares++;
            $display("FAIL pre_reset_en: got %b want %b", digit_en, 4'b0100);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (digit_en !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_en: got %b want %b", digit_en, 4'b0000);
        end
        vectors++;
        if (bcd !== 4'h0) begin
            miscompares++;
            $display("FAIL async_reset_bcd: got %h want %h", bcd, 4'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        cyc     = 0;
        lt_prev = 1'b0;
        check_frame(16'h0000, 4'b0000, -1, 16'h0, -1, 16'h0, -1);
        check_frame(16'h0000, 4'b0000, -1, 16'h0, -1, 16'h0, -1);
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_steady_scan();
        test_blank_lz();
        test_lamp_test();
        test_back_to_back();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
